// File: rtl/move_executor.sv
// move_executor: runs one board move as a fixed 7-state sequence
// (read attacker, read target, evaluate, write target, write source, done).
// Board RAM has a one-cycle read latency; cells are addressed {y,x}.
// Optional feature macro CAPTURE_COUNT_EN adds per-team lost-piece counters.
module move_executor (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [2:0] src_x,
  input  logic [2:0] src_y,
  input  logic [2:0] dst_x,
  input  logic [2:0] dst_y,
  output logic [5:0] ram_addr,
  output logic [5:0] ram_wdata,
  output logic       ram_we,
  input  logic [5:0] ram_rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       win,
  output logic       winner,
  output logic [3:0] lost_p0,
  output logic [3:0] lost_p1
);

  localparam logic [1:0] CmdCapture = 2'b00;
  localparam logic [1:0] CmdTrade   = 2'b10;
  localparam logic [1:0] CmdRsvd    = 2'b11;
  localparam logic [5:0] PieceBlank = 6'b000000;
  localparam logic [5:0] PieceWall  = 6'b111111;
  localparam logic [4:0] TypeFlag   = 5'b00001;

  typedef enum logic [2:0] {
    StIdle, StRdSrc, StRdDst, StEval, StWrDst, StWrSrc, StDone
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cmd_q;
  logic [5:0] src_addr_q, dst_addr_q;
  logic [5:0] src_piece_q, dst_piece_q;
  logic       winner_q;
  logic       bad;
  logic       win_cond;

  // Illegal move: empty or impassable attacker, or impassable target.
  assign bad      = (src_piece_q == PieceBlank) || (src_piece_q == PieceWall) ||
                    (dst_piece_q == PieceWall);
  assign win_cond = (cmd_q == CmdCapture) && !bad && (dst_piece_q[5:1] == TypeFlag);
  assign busy     = (state_q != StIdle);
  assign winner   = winner_q;

  // State register and latched move context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= 2'b00;
      src_addr_q  <= 6'd0;
      dst_addr_q  <= 6'd0;
      src_piece_q <= 6'd0;
      dst_piece_q <= 6'd0;
      winner_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        cmd_q      <= cmd;
        src_addr_q <= {src_y, src_x};
        dst_addr_q <= {dst_y, dst_x};
      end
      if (state_q == StRdDst) src_piece_q <= ram_rdata;
      if (state_q == StEval)  dst_piece_q <= ram_rdata;
      // Update before DONE so winner is valid alongside the win pulse.
      if (state_q == StWrSrc && win_cond) winner_q <= src_piece_q[0];
    end
  end

  // Next-state sequencing and RAM/status outputs.
  always_comb begin
    state_d   = state_q;
    ram_addr  = 6'd0;
    ram_wdata = 6'd0;
    ram_we    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    win       = 1'b0;
    case (state_q)
      StIdle:  if (start) state_d = StRdSrc;
      StRdSrc: begin
        ram_addr = src_addr_q;
        state_d  = StRdDst;
      end
      StRdDst: begin
        ram_addr = dst_addr_q;
        state_d  = StEval;
      end
      StEval:  state_d = StWrDst;
      StWrDst: begin
        ram_addr = dst_addr_q;
        if (!bad && cmd_q == CmdCapture) begin
          ram_we    = 1'b1;
          ram_wdata = src_piece_q;
        end else if (!bad && cmd_q == CmdTrade) begin
          ram_we = 1'b1;
        end
        state_d = StWrSrc;
      end
      StWrSrc: begin
        ram_addr = src_addr_q;
        ram_we   = !bad && (cmd_q != CmdRsvd);
        state_d  = StDone;
      end
      StDone: begin
        done    = 1'b1;
        err     = bad;
        win     = win_cond;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CAPTURE_COUNT_EN
  logic       remove_en;
  logic       remove_team;
  logic [3:0] lost_p0_q, lost_p1_q;

  // A removal is any legal write that clears or overwrites a non-blank piece.
  always_comb begin
    remove_en   = 1'b0;
    remove_team = 1'b0;
    if (!bad && state_q == StWrDst && (cmd_q == CmdCapture || cmd_q == CmdTrade) &&
        dst_piece_q != PieceBlank) begin
      remove_en   = 1'b1;
      remove_team = dst_piece_q[0];
    end else if (!bad && state_q == StWrSrc && cmd_q != CmdRsvd) begin
      remove_en   = 1'b1;
      remove_team = src_piece_q[0];
    end
  end

  // Saturating per-team removal counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_p0_q <= 4'd0;
      lost_p1_q <= 4'd0;
    end else if (remove_en) begin
      if (!remove_team && lost_p0_q != 4'hf) lost_p0_q <= lost_p0_q + 4'd1;
      if (remove_team && lost_p1_q != 4'hf)  lost_p1_q <= lost_p1_q + 4'd1;
    end
  end

  assign lost_p0 = lost_p0_q;
  assign lost_p1 = lost_p1_q;
`else
  assign lost_p0 = 4'd0;
  assign lost_p1 = 4'd0;
`endif

endmodule

// File: tb/tb_move_executor.sv
// Self-checking bench for move_executor: RAM model plus a board-level reference.
module tb_move_executor;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] cmd;
  logic [2:0] src_x, src_y, dst_x, dst_y;
  logic [5:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we, busy, done, err, win, winner;
  logic [3:0] lost_p0, lost_p1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] mem[64];
  logic [5:0] img[64];
  logic [5:0] ref_board[64];
  logic       load = 1'b0;
  logic       m_winner;
  int         m_lost[2];

  always #5 clk = ~clk;

  move_executor dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err(err), .win(win), .winner(winner),
    .lost_p0(lost_p0), .lost_p1(lost_p1)
  );

  // Synchronous board RAM, one-cycle read latency, with a bulk-load port.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= img[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] rand_piece();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 6'd0;
    if (r == 2) return 6'h3f;
    if (r == 3) return {5'b00001, 1'($urandom)};
    return 6'($urandom_range(2, 62));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) img[i] = rand_piece();
  endtask

  task automatic commit_board();
    for (int i = 0; i < 64; i++) ref_board[i] = img[i];
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic model_reset();
    m_winner  = 1'b0;
    m_lost[0] = 0;
    m_lost[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic check_board(input string tag);
    int bad_i;
    bad_i = -1;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_board[i] && bad_i < 0) bad_i = i;
    n_cmp++;
    if (bad_i >= 0) begin
      n_bad++;
      $display("FAIL %s board: cell %0d got %b want %b", tag, bad_i, mem[bad_i],
               ref_board[bad_i]);
    end
  endtask

  // One move: reference result from board rules, then drive and observe from IDLE.
  task automatic move(input logic [1:0] c, input logic [2:0] sx, input logic [2:0] sy,
                      input logic [2:0] dx, input logic [2:0] dy, input bit hold,
                      input int pulse_at, input string tag);
    logic [5:0] sa, da, sp, dp;
    bit         e_err, e_win, busy_ok, idle_ok, wr_ok;
    logic [5:0] ea[$], ed[$], ga[$], gd[$];
    int         done_cyc, n_done, e_l0, e_l1;
    logic       g_err, g_win, g_winner;
    logic [3:0] g_l0, g_l1;
    sa = {sy, sx};
    da = {dy, dx};
    sp = ref_board[sa];
    dp = ref_board[da];
    e_err = (sp == 6'd0) || (sp == 6'h3f) || (dp == 6'h3f);
    e_win = (c == 2'b00) && !e_err && (dp[5:1] == 5'd1);
    if (!e_err) begin
      if (c == 2'b00) begin ea.push_back(da); ed.push_back(sp); end
      if (c == 2'b10) begin ea.push_back(da); ed.push_back(6'd0); end
      if (c != 2'b11) begin ea.push_back(sa); ed.push_back(6'd0); end
      if ((c == 2'b00 || c == 2'b10) && dp != 6'd0 && m_lost[dp[0]] < 15) m_lost[dp[0]]++;
      if (c != 2'b11 && m_lost[sp[0]] < 15) m_lost[sp[0]]++;
    end
    foreach (ea[i]) ref_board[ea[i]] = ed[i];
    if (e_win) m_winner = sp[0];
`ifdef CAPTURE_COUNT_EN
    e_l0 = m_lost[0];
    e_l1 = m_lost[1];
`else
    e_l0 = 0;
    e_l1 = 0;
`endif
    cmd = c; src_x = sx; src_y = sy; dst_x = dx; dst_y = dy; start = 1'b1;
    done_cyc = -1; n_done = 0; busy_ok = 1; idle_ok = 1;
    g_err = 1'bx; g_win = 1'bx; g_winner = 1'bx; g_l0 = 4'hx; g_l1 = 4'hx;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        if (!hold) start = 1'b0;
        // Inputs change after acceptance; the move must use latched values.
        cmd = 2'($urandom); src_x = 3'($urandom); dst_y = 3'($urandom);
      end
      if (pulse_at != 0 && k == pulse_at) start = 1'b1;
      if (pulse_at != 0 && k == pulse_at + 1) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 0;
      if (ram_we === 1'b1) begin ga.push_back(ram_addr); gd.push_back(ram_wdata); end
      if (done === 1'b1) begin
        n_done++; done_cyc = k;
        g_err = err; g_win = win; g_winner = winner; g_l0 = lost_p0; g_l1 = lost_p1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) idle_ok = 0;

    n_cmp++;
    if (done_cyc != 6 || n_done != 1) begin
      n_bad++;
      $display("FAIL %s done_timing: got cycle %0d count %0d want cycle 6 count 1", tag,
               done_cyc, n_done);
    end
    n_cmp++;
    if (!busy_ok || !idle_ok) begin
      n_bad++;
      $display("FAIL %s busy_idle: got busy_ok %0d idle_ok %0d want 1 1", tag, busy_ok, idle_ok);
    end
    n_cmp++;
    if (g_err !== e_err) begin
      n_bad++;
      $display("FAIL %s err: got %b want %b", tag, g_err, e_err);
    end
    n_cmp++;
    if (g_win !== e_win || g_winner !== m_winner) begin
      n_bad++;
      $display("FAIL %s win: got win %b winner %b want win %b winner %b", tag, g_win, g_winner,
               e_win, m_winner);
    end
    wr_ok = (ga.size() == ea.size());
    if (wr_ok) foreach (ea[i]) if (ga[i] !== ea[i] || gd[i] !== ed[i]) wr_ok = 0;
    n_cmp++;
    if (!wr_ok) begin
      n_bad++;
      $display("FAIL %s writes: got %0d writes (first %0d:%b) want %0d writes (first %0d:%b)",
               tag, ga.size(), (ga.size() > 0) ? ga[0] : 6'd0, (gd.size() > 0) ? gd[0] : 6'd0,
               ea.size(), (ea.size() > 0) ? ea[0] : 6'd0, (ed.size() > 0) ? ed[0] : 6'd0);
    end
    n_cmp++;
    if (g_l0 !== 4'(e_l0) || g_l1 !== 4'(e_l1)) begin
      n_bad++;
      $display("FAIL %s lost: got %0d/%0d want %0d/%0d", tag, g_l0, g_l1, e_l0, e_l1);
    end
    check_board(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, win, winner, ram_we} !== 6'd0 || ram_addr !== 6'd0 ||
        ram_wdata !== 6'd0 || lost_p0 !== 4'd0 || lost_p1 !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got flags %b addr %0d wdata %0d lost %0d/%0d want all 0",
               {busy, done, err, win, winner, ram_we}, ram_addr, ram_wdata, lost_p0, lost_p1);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_capture();
    fill_random();
    img[17] = 6'b001000;
    img[18] = 6'b000000;
    commit_board();
    move(2'b00, 3'd1, 3'd2, 3'd2, 3'd2, 0, 0, "capture");
    n_cmp++;
    if (mem[18] !== 6'b001000 || mem[17] !== 6'b000000) begin
      n_bad++;
      $display("FAIL capture_cells: got %b/%b want 001000/000000", mem[18], mem[17]);
    end
  endtask

  task automatic test_flag_win();
    fill_random();
    img[0] = 6'b001001;
    img[1] = 6'b000010;
    commit_board();
    move(2'b00, 3'd0, 3'd0, 3'd1, 3'd0, 0, 0, "flag_win");
    n_cmp++;
    if (mem[1] !== 6'b001001 || winner !== 1'b1) begin
      n_bad++;
      $display("FAIL flag_win_cell: got %b winner %b want 001001 winner 1", mem[1], winner);
    end
  endtask

  task automatic test_trade();
    do_reset();
    fill_random();
    img[45] = 6'b000111;
    img[46] = 6'b000110;
    commit_board();
    move(2'b10, 3'd5, 3'd5, 3'd6, 3'd5, 0, 0, "trade");
    n_cmp++;
`ifdef CAPTURE_COUNT_EN
    if (lost_p0 !== 4'd1 || lost_p1 !== 4'd1 || mem[45] !== 6'd0 || mem[46] !== 6'd0) begin
`else
    if (lost_p0 !== 4'd0 || lost_p1 !== 4'd0 || mem[45] !== 6'd0 || mem[46] !== 6'd0) begin
`endif
      n_bad++;
      $display("FAIL trade_result: got lost %0d/%0d cells %b/%b", lost_p0, lost_p1, mem[45],
               mem[46]);
    end
  endtask

  task automatic test_blank_src();
    fill_random();
    img[50] = 6'b000000;
    img[51] = 6'b010100;
    commit_board();
    move(2'b00, 3'd2, 3'd6, 3'd3, 3'd6, 0, 0, "blank_src");
  endtask

  task automatic test_start_while_busy();
    fill_random();
    img[9]  = 6'b000100;
    img[10] = 6'b000011;
    commit_board();
    move(2'b00, 3'd1, 3'd1, 3'd2, 3'd1, 0, 2, "start_busy");
  endtask

  task automatic test_back_to_back();
    fill_random();
    img[20] = 6'b010101;
    img[21] = 6'b000000;
    img[30] = 6'b011000;
    img[31] = 6'b011011;
    commit_board();
    move(2'b00, 3'd4, 3'd2, 3'd5, 3'd2, 1, 0, "b2b_first");
    move(2'b10, 3'd6, 3'd3, 3'd7, 3'd3, 1, 0, "b2b_second");
    move(2'b01, 3'd5, 3'd2, 3'd6, 3'd3, 0, 0, "b2b_third");
  endtask

  task automatic test_reset_mid();
    int extra;
    fill_random();
    img[27] = 6'b000101;
    img[36] = 6'b000000;
    commit_board();
    cmd = 2'b00; src_x = 3'd3; src_y = 3'd3; dst_x = 3'd4; dst_y = 3'd4; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 6'd36) begin
      n_bad++;
      $display("FAIL reset_mid_wrdst: got we %b addr %0d want we 1 addr 36", ram_we, ram_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: got we %b busy %b done %b want 0 0 0", ram_we, busy, done);
    end
    model_reset();
    @(negedge clk) reset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || ram_we === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", extra);
    end
    check_board("reset_mid");
    move(2'b00, 3'd3, 3'd3, 3'd4, 3'd4, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [2:0] sx, sy, dx, dy;
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) begin
        fill_random();
        commit_board();
      end
      sx = 3'($urandom); sy = 3'($urandom); dx = 3'($urandom); dy = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin dx = sx; dy = sy; end
      move(2'($urandom), sx, sy, dx, dy, 0, 0, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 2'b00;
    src_x = 3'd0; src_y = 3'd0; dst_x = 3'd0; dst_y = 3'd0;
    for (int i = 0; i < 64; i++) img[i] = 6'd0;
    model_reset();
    test_reset();
    test_capture();
    test_flag_win();
    test_trade();
    test_blank_src();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
REQ-003 SHALL have: start  in  1  request to execute one move; sampled only in IDLE.
REQ-004 SHALL have: cmd  in  2  00 CAPTURE, 01 DIE, 10 TRADE, 11 reserved.
REQ-005 SHALL have: src_x, src_y, dst_x, dst_y  in  3 each  attacker and target cells.
REQ-006 SHALL have: ram_addr  out  6  board cell address = {y,x}.
REQ-007 SHALL have: ram_wdata  out  6  piece to write; ram_we  out  1  write strobe.
REQ-008 SHALL have: ram_rdata  in  6  board read data, valid one cycle after ram_addr.
REQ-009 SHALL have: busy  out  1; done  out  1; err  out  1; win  out  1; winner  out  1.
REQ-010 SHALL have: lost_p0, lost_p1  out  4 each  pieces removed per team.

Function
REQ-011 Piece encoding SHALL be bit0 = team, bits[5:1] = type; 000000 = blank, 111111 = impassable, type 00001 = flag.
REQ-012 FSM states SHALL be IDLE, RD_SRC, RD_DST, EVAL, WR_DST, WR_SRC, DONE, stepping one state per cycle in that order.
REQ-013 In IDLE, start=1 SHALL latch cmd and all coordinates and move to RD_SRC; start in any other state SHALL be ignored.
REQ-014 RD_SRC SHALL drive ram_addr={src_y,src_x}; RD_DST SHALL drive ram_addr={dst_y,dst_x} and latch ram_rdata as src_piece.
REQ-015 EVAL SHALL latch ram_rdata as dst_piece; ram_we SHALL be 0 in IDLE, RD_SRC, RD_DST, EVAL, DONE.
REQ-016 WR_DST SHALL drive dst address: CAPTURE writes src_piece; TRADE writes 000000; DIE and 11 do not write.
REQ-017 WR_SRC SHALL drive src address: CAPTURE, DIE, TRADE write 000000; 11 does not write.
REQ-018 If src_piece is 000000 or 111111, or dst_piece is 111111, WR_DST and WR_SRC SHALL not write and err SHALL pulse with done.
REQ-019 done SHALL be high for exactly one cycle in DONE, 6 cycles after the start-accept edge; the state sequence is fixed regardless of cmd.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 win SHALL pulse with done when cmd=CAPTURE, no err, and dst_piece[5:1]=00001; winner SHALL be src_piece[0] and hold until next win.
REQ-022 start held high continuously SHALL start a new move on the cycle after DONE (IDLE accepts it).
REQ-023 src equal to dst SHALL execute normally without special casing (sequence and writes per cmd).

Reset
REQ-024 Reset SHALL force IDLE immediately; busy, done, err, win, winner, ram_we=0, ram_addr=0, ram_wdata=0, latched registers=0.
REQ-025 Reset mid-move SHALL abandon the move; no further writes occur and done does not pulse.
REQ-026 lost_p0/lost_p1 SHALL reset to 0.

Configuration
REQ-027 Macro CAPTURE_COUNT_EN SHALL, when defined, enable counters: each non-err write of 000000 over a non-blank piece increments lost_p<team of removed piece>, saturating at 15.
REQ-028 Counting SHALL use src_piece for the write in WR_SRC and dst_piece for the write in WR_DST; a CAPTURE overwriting a non-blank dst SHALL count dst_piece's team.
REQ-029 Without CAPTURE_COUNT_EN, lost_p0 and lost_p1 SHALL be constant 0 and no counter logic is instantiated.

Verification
REQ-030 Board (1,2)=001000, (2,2)=000000; start, cmd=00, src=(1,2), dst=(2,2) -> write addr 18 data 001000, then addr 17 data 000000; done at cycle 6; err=0.
REQ-031 src piece 001001, dst piece 000010 (team0 flag); cmd=00 -> win=1, winner=1 with done; dst holds 001001.
REQ-032 cmd=10 on src 000111, dst 000110 -> both cells written 000000; with CAPTURE_COUNT_EN lost_p1=1, lost_p0=1.
REQ-033 src cell 000000, cmd=00 -> ram_we never high, err=1 and done=1 together.
REQ-034 Assert reset during WR_DST -> ram_we low same cycle, FSM IDLE, no done; subsequent start completes normally.
REQ-035 Pulse start while busy (RD_DST) -> ignored; exactly one done for the accepted move.
